regfile_wb_scheduler: RTL and testbench
=======================================

Name: regfile_wb_scheduler

Overview:
- Scoreboard plus write-port arbiter for the 16x8 register file (2 synchronous read ports, 1 write port).
- Holds instruction issue while a source or destination register has a write still in flight.
- Round-robin arbitrates two writeback requesters (wb0 = ALU, wb1 = load unit) onto the single write port.
- Drives the register file's write enable, destination and data from registers.

Parameters:
- NREG, 16, number of architectural registers.
- AW, 4, register index width (log2 NREG).
- DW, 8, data width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- iss_valid  in  1  decode presents an instruction
- iss_ready  out  1  instruction accepted this cycle (combinational)
- iss_src_a  in  AW  read-port A index
- iss_src_b  in  AW  read-port B index
- iss_dest  in  AW  destination index
- iss_wr  in  1  instruction will write iss_dest
- wb0_valid  in  1  ALU result pending
- wb0_ready  out  1  ALU result granted (combinational)
- wb0_dest  in  AW  ALU destination
- wb0_data  in  DW  ALU result
- wb1_valid / wb1_ready / wb1_dest / wb1_data: same as wb0, for the load unit
- rf_wrt  out  1  register-file write enable (registered)
- rf_dest  out  AW  register-file write index (registered)
- rf_data  out  DW  register-file write data (registered)
- busy_vec  out  NREG  scoreboard bits, bit i = write to Ri pending
- wb_err  out  1  sticky protocol error

Behaviour:
- Reset (async, rst_n=0): busy_vec=0, rf_wrt=0, rf_dest=0, rf_data=0, wb_err=0, RR pointer "last granted" = wb1 (so wb0 wins first). Reset mid-operation drops all pending state; requesters must re-present.
- R0 is never busy. busy_vec[0] is constant 0.
- Hazard:
  - hz = busy[src_a] | busy[src_b] | (iss_wr & busy[dest]).
  - iss_ready = iss_valid & !hz.
- Issue acceptance: on accept with iss_wr=1 and dest!=0, busy[dest] sets at that edge.
- Arbitration:
  - Exactly one wb grant per cycle at most.
  - Only one valid: grant it.
  - Both valid: grant the one not last granted.
  - The pointer updates only on a grant.
  - wbX_ready = grant.
- Transfer: a handshake completes when valid & ready. Requesters hold dest/data stable until ready.
- Write port timing: a grant at edge N sets rf_wrt=1, rf_dest, rf_data at edge N. The register file commits at edge N+1, and rf_wrt returns to 0 there unless another grant occurs. Back-to-back grants give rf_wrt high continuously, one write per cycle.
- Busy clear: busy[rf_dest] clears at the edge where rf_wrt=1, i.e. the same edge the register file commits.
  - The register file read at that edge still returns the old value, so issue stays blocked through that cycle.
  - The first dependent issue reads the new value one cycle later.
- Write to R0 from wb: handshake completes normally, rf_wrt stays 0, busy unaffected.
- Writeback to a register whose busy bit is 0 (excluding R0): the write is still performed and wb_err sets; wb_err clears only on reset.
- Set and clear on the same register in one cycle cannot occur: WAW blocks issue while busy. No priority rule is needed.
- Independent destinations: up to NREG-1 writes may be outstanding. Order of completion is free.

Decomposition:
- Package regfile_pkg: NREG, AW, DW, constant R_ZERO=0, and the wb-source enum (WB_ALU=0, WB_LOAD=1).
- One sub-module: rr_arb2 (2-way round-robin arbiter: req[1:0] in, gnt[1:0] out, pointer register with async active-low reset).
- Scoreboard and write-port registers live in regfile_wb_scheduler.

Test Plan:
- Reset then idle: busy_vec=0, rf_wrt=0, wb_err=0. Issue src_a=1, src_b=2, dest=3, wr=1: iss_ready=1 the same cycle, busy_vec=0x0008 next cycle.
- RAW stall: busy[3] set; issue src_a=3 -> iss_ready=0. wb0 dest=3, data=0x5A: granted, rf_wrt=1/rf_dest=3/rf_data=0x5A for one cycle, busy[3] clears at the commit edge. iss_ready=1 on the following cycle.
- Contention: wb0 (dest 4, 0x11) and wb1 (dest 5, 0x22) valid on the same cycle after reset, both held. wb0 granted first, then wb1. rf_wrt high for 2 consecutive cycles, writes 0x11 then 0x22. Repeated simultaneous requests alternate.
- WAW: dest=6 busy, issue dest=6 wr=1 srcs clean -> stalled. The same with wr=0 -> accepted.
- R0 and error: wb1 dest=0 -> ready=1, rf_wrt stays 0, wb_err=0. wb0 to non-busy R7 -> write performed, wb_err=1 and held.
- Async reset asserted mid-stream with busy_vec=0x00F0 and rf_wrt=1 -> all outputs zero immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared sizes, the R0 index and writeback source encoding for the
// register-file writeback scheduler.
package regfile_pkg;
  localparam int NREG = 16;
  localparam int AW   = 4;
  localparam int DW   = 8;

  localparam logic [AW-1:0] R_ZERO = '0;

  typedef enum logic {
    WB_ALU  = 1'b0,
    WB_LOAD = 1'b1
  } wb_src_e;
endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Issue, writeback and register-file write-port signals of the scheduler.
// The master drives issue/writeback requests; the slave is the scheduler.
interface regfile_wb_scheduler_if;
  import regfile_pkg::*;

  logic            iss_valid;
  logic            iss_ready;
  logic [AW-1:0]   iss_src_a;
  logic [AW-1:0]   iss_src_b;
  logic [AW-1:0]   iss_dest;
  logic            iss_wr;

  logic            wb0_valid;
  logic            wb0_ready;
  logic [AW-1:0]   wb0_dest;
  logic [DW-1:0]   wb0_data;

  logic            wb1_valid;
  logic            wb1_ready;
  logic [AW-1:0]   wb1_dest;
  logic [DW-1:0]   wb1_data;

  logic            rf_wrt;
  logic [AW-1:0]   rf_dest;
  logic [DW-1:0]   rf_data;
  logic [NREG-1:0] busy_vec;
  logic            wb_err;

  modport master (
    output iss_valid, iss_src_a, iss_src_b, iss_dest, iss_wr,
    output wb0_valid, wb0_dest, wb0_data,
    output wb1_valid, wb1_dest, wb1_data,
    input  iss_ready, wb0_ready, wb1_ready,
    input  rf_wrt, rf_dest, rf_data, busy_vec, wb_err
  );

  modport slave (
    input  iss_valid, iss_src_a, iss_src_b, iss_dest, iss_wr,
    input  wb0_valid, wb0_dest, wb0_data,
    input  wb1_valid, wb1_dest, wb1_data,
    output iss_ready, wb0_ready, wb1_ready,
    output rf_wrt, rf_dest, rf_data, busy_vec, wb_err
  );
endinterface

// File: rtl/regfile_wb_scheduler_rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last granted
// requester and only moves when a grant is issued.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  wb_src_e last;

  // Reset to the load unit so the ALU wins the first contended cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last <= WB_LOAD;
    else if (gnt[0])
      last <= WB_ALU;
    else if (gnt[1])
      last <= WB_LOAD;
  end

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == WB_LOAD) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register scoreboard plus writeback arbitration onto the single
// register-file write port; holds issue while operands are in flight.
module regfile_wb_scheduler
  import regfile_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  regfile_wb_scheduler_if.slave  bus
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_next;
  logic            rf_wrt_q;
  logic [AW-1:0]   rf_dest_q;
  logic [DW-1:0]   rf_data_q;
  logic            wb_err_q;

  logic            hz;
  logic            accept;
  logic [1:0]      gnt;
  logic            any_gnt;
  logic [AW-1:0]   sel_dest;
  logic [DW-1:0]   sel_data;
  logic            sel_real;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({bus.wb1_valid, bus.wb0_valid}),
    .gnt   (gnt)
  );

  assign hz     = busy_q[bus.iss_src_a] | busy_q[bus.iss_src_b]
                | (bus.iss_wr & busy_q[bus.iss_dest]);
  assign accept = bus.iss_valid & ~hz;

  assign any_gnt  = |gnt;
  assign sel_dest = gnt[1] ? bus.wb1_dest : bus.wb0_dest;
  assign sel_data = gnt[1] ? bus.wb1_data : bus.wb0_data;
  assign sel_real = any_gnt & (sel_dest != R_ZERO);

  // Clear happens at the commit edge; a set on the same index only arises
  // after an erroneous write, in which case the new issue's set wins.
  always_comb begin
    busy_next = busy_q;
    if (rf_wrt_q)
      busy_next[rf_dest_q] = 1'b0;
    if (accept && bus.iss_wr && (bus.iss_dest != R_ZERO))
      busy_next[bus.iss_dest] = 1'b1;
    busy_next[R_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= '0;
      rf_wrt_q  <= 1'b0;
      rf_dest_q <= '0;
      rf_data_q <= '0;
      wb_err_q  <= 1'b0;
    end else begin
      busy_q   <= busy_next;
      rf_wrt_q <= sel_real;
      if (sel_real) begin
        rf_dest_q <= sel_dest;
        rf_data_q <= sel_data;
        if (!busy_q[sel_dest])
          wb_err_q <= 1'b1;
      end
    end
  end

  assign bus.iss_ready = accept;
  assign bus.wb0_ready = gnt[0];
  assign bus.wb1_ready = gnt[1];
  assign bus.rf_wrt    = rf_wrt_q;
  assign bus.rf_dest   = rf_dest_q;
  assign bus.rf_data   = rf_data_q;
  assign bus.busy_vec  = busy_q;
  assign bus.wb_err    = wb_err_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed and randomized checks of the writeback scheduler against a
// cycle-level behavioural model of scoreboard, arbitration and write port.
module tb_regfile_wb_scheduler;
  import regfile_pkg::*;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  regfile_wb_scheduler_if ifc ();

  regfile_wb_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bit         m_busy [NREG];
  int         m_last;
  bit         m_wrt;
  logic [3:0] m_dest;
  logic [7:0] m_data;
  bit         m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_busy_vec();
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < NREG; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
    m_last = 1;
    m_wrt  = 1'b0;
    m_dest = '0;
    m_data = '0;
    m_err  = 1'b0;
  endtask

  task automatic idle_inputs();
    ifc.iss_valid = 0; ifc.iss_src_a = 0; ifc.iss_src_b = 0; ifc.iss_dest = 0; ifc.iss_wr = 0;
    ifc.wb0_valid = 0; ifc.wb0_dest = 0; ifc.wb0_data = 0;
    ifc.wb1_valid = 0; ifc.wb1_dest = 0; ifc.wb1_data = 0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_inputs();
    #1;
    model_reset();
    check("rst_busy", ifc.busy_vec, 0);
    check("rst_rf_wrt", ifc.rf_wrt, 0);
    check("rst_rf_dest", ifc.rf_dest, 0);
    check("rst_rf_data", ifc.rf_data, 0);
    check("rst_wb_err", ifc.wb_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: check combinational outputs, step the model on the edge,
  // then check registered outputs shortly after the edge.
  task automatic cycle(output bit rdy, output bit g0, output bit g1);
    bit         hz, v0, v1, old_busy [NREG];
    logic [3:0] d;
    logic [7:0] dat;
    logic [3:0] sa, sb, dst;
    bit         wr;
    #1;
    sa = ifc.iss_src_a; sb = ifc.iss_src_b; dst = ifc.iss_dest; wr = ifc.iss_wr;
    v0 = ifc.wb0_valid; v1 = ifc.wb1_valid;
    hz  = m_busy[sa] || m_busy[sb] || (wr && m_busy[dst]);
    rdy = ifc.iss_valid && !hz;
    g0  = v0 && (!v1 || m_last == 1);
    g1  = v1 && (!v0 || m_last == 0);
    check("iss_ready", ifc.iss_ready, rdy);
    check("wb0_ready", ifc.wb0_ready, g0);
    check("wb1_ready", ifc.wb1_ready, g1);
    d   = g1 ? ifc.wb1_dest : ifc.wb0_dest;
    dat = g1 ? ifc.wb1_data : ifc.wb0_data;
    @(posedge clk);
    old_busy = m_busy;
    if (m_wrt) m_busy[m_dest] = 1'b0;
    if (rdy && wr && dst != 0) m_busy[dst] = 1'b1;
    m_wrt = 1'b0;
    if (g0 || g1) begin
      m_last = g1 ? 1 : 0;
      if (d != 0) begin
        if (!old_busy[d]) m_err = 1'b1;
        m_wrt  = 1'b1;
        m_dest = d;
        m_data = dat;
      end
    end
    #1;
    check("rf_wrt", ifc.rf_wrt, m_wrt);
    if (m_wrt) begin
      check("rf_dest", ifc.rf_dest, m_dest);
      check("rf_data", ifc.rf_data, m_data);
    end
    check("busy_vec", ifc.busy_vec, model_busy_vec());
    check("wb_err", ifc.wb_err, m_err);
  endtask

  task automatic issue(input logic [3:0] sa, input logic [3:0] sb, input logic [3:0] d,
                       input bit wr, output bit rdy);
    bit g0, g1;
    ifc.iss_valid = 1; ifc.iss_src_a = sa; ifc.iss_src_b = sb; ifc.iss_dest = d; ifc.iss_wr = wr;
    cycle(rdy, g0, g1);
    ifc.iss_valid = 0;
  endtask

  function automatic logic [3:0] pick_dest(input logic [3:0] avoid, input bit avoid_en);
    logic [3:0] q[$];
    for (int i = 1; i < NREG; i++)
      if (m_busy[i] && !(avoid_en && avoid == i[3:0])) q.push_back(i[3:0]);
    if (q.size() > 0 && $urandom_range(0, 7) != 0)
      return q[$urandom_range(0, q.size() - 1)];
    return 4'($urandom_range(0, NREG - 1));
  endfunction

  initial begin
    bit rdy, g0, g1, p0, p1;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    apply_reset();

    // basic issue
    issue(1, 2, 3, 1, rdy);
    check("t1_ready", rdy, 1);
    check("t1_busy", ifc.busy_vec, 16'h0008);

    // RAW stall and release through wb0
    ifc.iss_valid = 1; ifc.iss_src_a = 3; ifc.iss_src_b = 0; ifc.iss_dest = 0; ifc.iss_wr = 0;
    ifc.wb0_valid = 1; ifc.wb0_dest = 3; ifc.wb0_data = 8'h5A;
    cycle(rdy, g0, g1);
    check("raw_stall", rdy, 0);
    check("raw_g0", g0, 1);
    check("raw_rf", {ifc.rf_wrt, ifc.rf_dest, ifc.rf_data}, {1'b1, 4'd3, 8'h5A});
    ifc.wb0_valid = 0;
    cycle(rdy, g0, g1);
    check("raw_commit_stall", rdy, 0);
    check("raw_cleared", ifc.busy_vec, 0);
    cycle(rdy, g0, g1);
    check("raw_release", rdy, 1);
    ifc.iss_valid = 0;

    // contention right after reset
    apply_reset();
    issue(0, 0, 4, 1, rdy);
    issue(0, 0, 5, 1, rdy);
    ifc.wb0_valid = 1; ifc.wb0_dest = 4; ifc.wb0_data = 8'h11;
    ifc.wb1_valid = 1; ifc.wb1_dest = 5; ifc.wb1_data = 8'h22;
    cycle(rdy, g0, g1);
    check("cont_first_alu", {g1, g0}, 2'b01);
    check("cont_w1", {ifc.rf_wrt, ifc.rf_data}, {1'b1, 8'h11});
    ifc.wb0_valid = 0;
    cycle(rdy, g0, g1);
    check("cont_second_load", {g1, g0}, 2'b10);
    check("cont_w2", {ifc.rf_wrt, ifc.rf_data}, {1'b1, 8'h22});
    ifc.wb1_valid = 0;
    cycle(rdy, g0, g1);
    issue(0, 0, 4, 1, rdy);
    issue(0, 0, 5, 1, rdy);
    ifc.wb0_valid = 1; ifc.wb1_valid = 1;
    cycle(rdy, g0, g1);
    check("cont_alt1", {g1, g0}, 2'b01);
    ifc.wb0_dest = 5;
    ifc.wb1_dest = 4;
    cycle(rdy, g0, g1);
    check("cont_alt2", {g1, g0}, 2'b10);
    ifc.wb0_valid = 0; ifc.wb1_valid = 0;
    cycle(rdy, g0, g1);

    // WAW
    issue(0, 0, 6, 1, rdy);
    issue(1, 2, 6, 1, rdy);
    check("waw_stall", rdy, 0);
    issue(1, 2, 6, 0, rdy);
    check("waw_nowr", rdy, 1);
    ifc.wb0_valid = 1; ifc.wb0_dest = 6; ifc.wb0_data = 8'h66;
    cycle(rdy, g0, g1);
    ifc.wb0_valid = 0;
    cycle(rdy, g0, g1);

    // R0 write and error
    ifc.wb1_valid = 1; ifc.wb1_dest = 0; ifc.wb1_data = 8'hEE;
    cycle(rdy, g0, g1);
    check("r0_ready", g1, 1);
    check("r0_no_wr", ifc.rf_wrt, 0);
    check("r0_no_err", ifc.wb_err, 0);
    ifc.wb1_valid = 0;
    ifc.wb0_valid = 1; ifc.wb0_dest = 7; ifc.wb0_data = 8'h77;
    cycle(rdy, g0, g1);
    check("err_wr", {ifc.rf_wrt, ifc.rf_dest, ifc.rf_data}, {1'b1, 4'd7, 8'h77});
    check("err_set", ifc.wb_err, 1);
    ifc.wb0_valid = 0;
    repeat (3) cycle(rdy, g0, g1);
    check("err_sticky", ifc.wb_err, 1);

    // asynchronous reset mid-stream
    apply_reset();
    for (int r = 4; r < 8; r++) issue(0, 0, 4'(r), 1, rdy);
    ifc.wb0_valid = 1; ifc.wb0_dest = 4; ifc.wb0_data = 8'h44;
    cycle(rdy, g0, g1);
    check("mid_busy", ifc.busy_vec, 16'h00F0);
    check("mid_wrt", ifc.rf_wrt, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_busy", ifc.busy_vec, 0);
    check("async_wrt", ifc.rf_wrt, 0);
    check("async_dest", ifc.rf_dest, 0);
    check("async_data", ifc.rf_data, 0);
    check("async_err", ifc.wb_err, 0);
    apply_reset();

    // randomized traffic
    p0 = 0; p1 = 0;
    for (int n = 0; n < 3000; n++) begin
      ifc.iss_valid = 1'($urandom_range(0, 1));
      ifc.iss_src_a = 4'($urandom_range(0, NREG - 1));
      ifc.iss_src_b = 4'($urandom_range(0, NREG - 1));
      ifc.iss_dest  = 4'($urandom_range(0, NREG - 1));
      ifc.iss_wr    = 1'($urandom_range(0, 3) != 0);
      if (!p0 && $urandom_range(0, 2) == 0) begin
        p0 = 1;
        ifc.wb0_valid = 1;
        ifc.wb0_dest  = pick_dest(ifc.wb1_dest, p1);
        ifc.wb0_data  = 8'($urandom);
      end
      if (!p1 && $urandom_range(0, 2) == 0) begin
        p1 = 1;
        ifc.wb1_valid = 1;
        ifc.wb1_dest  = pick_dest(ifc.wb0_dest, p0);
        ifc.wb1_data  = 8'($urandom);
      end
      cycle(rdy, g0, g1);
      if (g0) begin p0 = 0; ifc.wb0_valid = 0; end
      if (g1) begin p1 = 0; ifc.wb1_valid = 0; end
      if (n == 1500) begin
        apply_reset();
        p0 = 0; p1 = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
